memory_arbiter: RTL

Shares one single-port unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the five-stage pipeline. Fixed-latency handshake toward memory, per-port ready pulses back to the pipeline, and a global `Stall` that freezes the pipeline while any access is outstanding. Data accesses have priority over instruction fetches.

---
 rtl/memory_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port memory between the instruction-fetch
// port and the data port of the pipeline. Data accesses win over fetches.
//
// Handshake: a requester raises its request (if_req, or d_read/d_write) and
// holds it with stable address/data until its ready output pulses for exactly
// one cycle. Ready pulses even if the request was dropped early; the access is
// never cancelled except by reset. Toward memory, mem_en is a one-cycle strobe
// and mem_rdata is sampled exactly LATENCY cycles after it.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  Stall,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_D = 3'd1,
    BUSY_I = 3'd2,
    RESP_D = 3'd3,
    RESP_I = 3'd4
  } state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t     state;
  logic [3:0] cnt;
  logic       write;

  // Arbitration FSM: grant, strobe memory once, wait LATENCY, capture, pulse ready.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      write     <= 1'b0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_read || d_write) begin
            // A simultaneous read+write is a store.
            state    <= BUSY_D;
            mem_addr <= d_addr;
            if (d_write) mem_wdata <= d_wdata;
            cnt      <= 4'd0;
            write    <= d_write;
            mem_en   <= 1'b1;
            mem_we   <= d_write;
          end else if (if_req) begin
            state    <= BUSY_I;
            mem_addr <= if_addr;
            cnt      <= 4'd0;
            write    <= 1'b0;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
          end
        end
        BUSY_D, BUSY_I: begin
          // The strobe only lives in the cnt=0 cycle.
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= cnt + 4'd1;
          if (cnt == LAT) begin
            if (state == BUSY_D) begin
              if (!write) d_rdata <= mem_rdata;
              d_ready <= 1'b1;
              state   <= RESP_D;
            end else begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
              state    <= RESP_I;
            end
          end
        end
        RESP_D, RESP_I: begin
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Freeze the pipeline while any port has a request not yet acknowledged.
  always_comb begin
    Stall = reset & ((if_req & ~if_ready) | ((d_read | d_write) & ~d_ready));
  end

  assign dbg_state = state;

endmodule
